// File: rtl/jtbubl_sdram_arb.sv
// Round-robin SDRAM read arbiter for four ROM slots.
// Each slot keeps a one-word tag cache so repeated reads need no SDRAM traffic.
module jtbubl_sdram_arb #(
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          downloading,
    input  logic          slot0_cs,
    input  logic          slot1_cs,
    input  logic          slot2_cs,
    input  logic          slot3_cs,
    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    output logic          slot0_ok,
    output logic          slot1_ok,
    output logic          slot2_ok,
    output logic          slot3_ok,
    output logic [DW-1:0] slot0_dout,
    output logic [DW-1:0] slot1_dout,
    output logic [DW-1:0] slot2_dout,
    output logic [DW-1:0] slot3_dout,
    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [DW-1:0] data_read,
    output logic          refresh_en
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rr_q, rr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          fill;

    logic [3:0]    valid_q;
    logic [AW-1:0] tag_q  [4];
    logic [DW-1:0] dout_q [4];

    logic [3:0]    cs, hit, pending;
    logic [AW-1:0] addr [4];
    logic [1:0]    pick, idx;
    logic          found;

    assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i] = valid_q[i] & (tag_q[i] == addr[i]);
        end
    end

    assign pending = cs & ~hit;

    // First pending slot after the last grant, wrapping 3 -> 0
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        idx   = rr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        fill    = 1'b0;
        if (downloading) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|pending) begin
                        gnt_d   = pick;
                        rr_d    = pick;
                        addr_d  = addr[pick];
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (sdram_ack) begin
                        req_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (data_rdy) begin
                        fill    = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            gnt_q   <= '0;
            rr_q    <= 2'd3;
            cnt_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            if (downloading) begin
                valid_q <= '0;
            end else if (fill) begin
                // Tag with the requested address; the slot may have moved on
                valid_q[gnt_q] <= 1'b1;
                tag_q[gnt_q]   <= addr_q;
                dout_q[gnt_q]  <= data_read;
            end
        end
    end

    assign slot0_ok   = cs[0] & hit[0];
    assign slot1_ok   = cs[1] & hit[1];
    assign slot2_ok   = cs[2] & hit[2];
    assign slot3_ok   = cs[3] & hit[3];
    assign slot0_dout = dout_q[0];
    assign slot1_dout = dout_q[1];
    assign slot2_dout = dout_q[2];
    assign slot3_dout = dout_q[3];
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = (state_q == S_IDLE) & ~|pending & ~downloading;

endmodule

// File: tb/tb_jtbubl_sdram_arb.sv
// Bench for jtbubl_sdram_arb: the stimulus queues expected SDRAM request
// addresses, a monitor checks each new request against that queue.
module tb_jtbubl_sdram_arb;

    localparam int AW = 22;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          downloading = 1'b0;
    logic [3:0]    cs = '0;
    logic [AW-1:0] addr [4];
    logic [3:0]    ok;
    logic [DW-1:0] dout [4];
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack = 1'b0;
    logic          data_rdy = 1'b0;
    logic [DW-1:0] data_read = '0;
    logic          refresh_en;

    int n_chk = 0;
    int n_fail = 0;
    logic [AW-1:0] exp_q [$];
    logic req_prev = 1'b0;

    jtbubl_sdram_arb dut (
        .clk(clk), .rstn(rstn), .downloading(downloading),
        .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]),
        .slot0_addr(addr[0]), .slot1_addr(addr[1]),
        .slot2_addr(addr[2]), .slot3_addr(addr[3]),
        .slot0_ok(ok[0]), .slot1_ok(ok[1]), .slot2_ok(ok[2]), .slot3_ok(ok[3]),
        .slot0_dout(dout[0]), .slot1_dout(dout[1]),
        .slot2_dout(dout[2]), .slot3_dout(dout[3]),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
        .refresh_en(refresh_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every new SDRAM request must match the head of the queue
    always @(negedge clk) begin
        if (sdram_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("req_unexpected", 64'(sdram_addr), 64'hFFFF_FFFF);
            end else begin
                check("req_addr", 64'(sdram_addr), 64'(exp_q.pop_front()));
            end
        end
        req_prev = sdram_req;
    end

    task automatic wait_req(input string nm, input int lim);
        int i = 0;
        while (!sdram_req && i < lim) begin
            @(negedge clk);
            i++;
        end
        check(nm, 64'(sdram_req), 64'd1);
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    task automatic do_rdy(input int dly, input logic [DW-1:0] d);
        repeat (dly) @(negedge clk);
        data_read = d;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        #1;
    endtask

    task automatic serve(input logic [DW-1:0] d);
        wait_req("req_seen", 20);
        do_ack(2);
        do_rdy(3, d);
    endtask

    task automatic do_reset();
        cs   = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) addr[i] = '0;
        @(negedge clk);
        do_reset();
        check("rst_req", 64'(sdram_req), 0);
        check("rst_addr", 64'(sdram_addr), 0);
        check("rst_refresh", 64'(refresh_en), 1);
        check("rst_dout0", 64'(dout[0]), 0);

        // Single miss then hit
        @(negedge clk);
        cs[0] = 1'b1; addr[0] = 22'h000100;
        exp_q.push_back(22'h000100);
        #1;
        check("miss_refresh_low", 64'(refresh_en), 0);
        check("miss_ok_low", 64'(ok[0]), 0);
        wait_req("req_seen", 20);
        do_ack(2);
        repeat (3) @(negedge clk);
        data_read = 32'hDEADBEEF; data_rdy = 1'b1;
        #1;
        check("ok_before_fill", 64'(ok[0]), 0);
        @(negedge clk);
        data_rdy = 1'b0;
        #1;
        check("fill_ok", 64'(ok[0]), 1);
        check("fill_dout", 64'(dout[0]), 64'hDEADBEEF);
        check("fill_refresh", 64'(refresh_en), 1);
        cs[0] = 1'b0;
        @(negedge clk);
        cs[0] = 1'b1;
        #1;
        check("hit_ok", 64'(ok[0]), 1);
        repeat (6) @(negedge clk);
        check("hit_no_req", 64'(sdram_req), 0);

        // Round robin from reset: 0,1,2,3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            addr[i] = 22'h1000 + 22'(i);
            exp_q.push_back(22'h1000 + 22'(i));
        end
        cs = 4'hF;
        for (int i = 0; i < 4; i++) serve(32'hA000_0000 + 32'(i));
        check("rr1_ok", 64'(ok), 64'hF);
        for (int i = 0; i < 4; i++) check("rr1_dout", 64'(dout[i]), 64'hA000_0000 + 64'(i));
        addr[0] = 22'h1100; addr[1] = 22'h1101;
        exp_q.push_back(22'h1100); exp_q.push_back(22'h1101);
        serve(32'hB000_0000);
        serve(32'hB000_0001);
        check("rr2_dout1", 64'(dout[1]), 64'hB000_0001);
        for (int i = 0; i < 4; i++) addr[i] = 22'h1200 + 22'(i);
        exp_q.push_back(22'h1202); exp_q.push_back(22'h1203);
        exp_q.push_back(22'h1200); exp_q.push_back(22'h1201);
        serve(32'hC000_0002);
        serve(32'hC000_0003);
        serve(32'hC000_0000);
        serve(32'hC000_0001);
        check("rr3_ok", 64'(ok), 64'hF);
        for (int i = 0; i < 4; i++) check("rr3_dout", 64'(dout[i]), 64'hC000_0000 + 64'(i));

        // Address change mid-transaction on slot 3
        cs = 4'b1000; addr[3] = 22'h20000;
        exp_q.push_back(22'h20000);
        wait_req("req_seen", 20);
        do_ack(2);
        addr[3] = 22'h20004;
        exp_q.push_back(22'h20004);
        do_rdy(3, 32'h3333_0000);
        check("chg_ok_low", 64'(ok[3]), 0);
        wait_req("chg_rereq", 5);
        addr[3] = 22'h20000;
        #1;
        check("chg_old_tag", 64'(ok[3]), 1);
        check("chg_old_dout", 64'(dout[3]), 64'h3333_0000);
        addr[3] = 22'h20004;
        do_ack(2);
        do_rdy(3, 32'h3333_4444);
        check("chg_new_ok", 64'(ok[3]), 1);
        check("chg_new_dout", 64'(dout[3]), 64'h3333_4444);

        // Timeout with no data_rdy
        cs[2] = 1'b1; addr[2] = 22'h3000;
        exp_q.push_back(22'h3000);
        wait_req("req_seen", 20);
        do_ack(1);
        exp_q.push_back(22'h3000);
        begin
            int i = 0;
            while (!sdram_req && i < 300) begin
                @(negedge clk);
                i++;
            end
            check("to_rereq", 64'(sdram_req), 1);
            check("to_waited", 64'(i >= 250), 1);
        end
        check("to_addr", 64'(sdram_addr), 64'h3000);
        check("to_ok_low", 64'(ok[2]), 0);
        do_ack(1);
        do_rdy(2, 32'h2222_0000);
        check("to_fill_ok", 64'(ok[2]), 1);
        check("to_fill_dout", 64'(dout[2]), 64'h2222_0000);

        // Download during WAIT
        cs[1] = 1'b1; addr[1] = 22'h5000;
        exp_q.push_back(22'h5000);
        wait_req("req_seen", 20);
        do_ack(1);
        downloading = 1'b1;
        @(negedge clk);
        #1;
        check("dl_req", 64'(sdram_req), 0);
        check("dl_ok", 64'(ok), 0);
        check("dl_refresh", 64'(refresh_en), 0);
        data_read = 32'hBAD0_BAD0; data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
        cs[2] = 1'b0; cs[3] = 1'b0;
        downloading = 1'b0;
        #1;
        check("dl_ok1_low", 64'(ok[1]), 0);
        exp_q.push_back(22'h5000);
        serve(32'h1111_5555);
        check("dl_refetch_dout", 64'(dout[1]), 64'h1111_5555);
        cs[2] = 1'b1;
        #1;
        check("dl_flushed", 64'(ok[2]), 0);
        exp_q.push_back(22'h3000);
        serve(32'h2222_1111);
        check("dl_refill2", 64'(dout[2]), 64'h2222_1111);

        // Idle with nothing selected
        cs = '0;
        @(negedge clk);
        #1;
        check("idle_refresh", 64'(refresh_en), 1);
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
